// File: rtl/uart.sv
// 8N1 UART with vector framing: transmits n_tx_nums 16-bit words high byte first
// and reassembles n_rx_nums received words, pulsing rx_available per full vector.
package uart_pkg;
    typedef logic signed [15:0] num;
endpackage

module uart #(
    parameter int n_tx_nums    = 5,
    parameter int n_rx_nums    = 5,
    parameter int CLKS_PER_BIT = 100
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          send_data,
    input  uart_pkg::num [n_tx_nums-1:0]  tx_nums,
    output logic                          tx_ready,
    output logic                          tx,
    input  logic                          rx,
    input  logic                          new_vector_incoming,
    output uart_pkg::num [n_rx_nums-1:0]  rx_nums,
    output logic                          rx_available
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'((CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 - 1 : 0);

    localparam int TX_BYTES = 2 * n_tx_nums;
    localparam int TBW      = (TX_BYTES > 1) ? $clog2(TX_BYTES) : 1;
    localparam int TVW      = 16 * n_tx_nums;
    localparam int RWW      = (n_rx_nums > 1) ? $clog2(n_rx_nums) : 1;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // ---------------------------------------------------------------- transmit
    tx_state_t        tx_state_q;
    logic [CW-1:0]    tx_cnt_q;
    logic [2:0]       tx_bit_q;
    logic [TBW-1:0]   tx_byte_q;
    logic [7:0]       tx_shift_q;
    logic [TVW-1:0]   tx_vec_q;
    logic [TVW-1:0]   tx_load_vec;
    logic             tx_q;
    logic             tx_ready_q;

    // Word 0 goes to the top of the vector so every byte is taken from the MSBs.
    for (genvar g = 0; g < n_tx_nums; g++) begin : g_tx_pack
        assign tx_load_vec[16*(n_tx_nums-1-g) +: 16] = tx_nums[g];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_byte_q  <= '0;
            tx_shift_q <= '0;
            tx_vec_q   <= '0;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (send_data && tx_ready_q) begin
                        tx_state_q <= TX_START;
                        tx_q       <= 1'b0;
                        tx_ready_q <= 1'b0;
                        tx_cnt_q   <= '0;
                        tx_byte_q  <= '0;
                        tx_shift_q <= tx_load_vec[TVW-1 -: 8];
                        tx_vec_q   <= tx_load_vec << 8;
                    end
                end
                TX_START: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_state_q <= TX_DATA;
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_q       <= tx_shift_q[0];
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 3'd7) begin
                            tx_state_q <= TX_STOP;
                            tx_q       <= 1'b1;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 1'b1;
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_q       <= tx_shift_q[1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_byte_q == TBW'(TX_BYTES - 1)) begin
                            tx_state_q <= TX_IDLE;
                            tx_ready_q <= 1'b1;
                            tx_byte_q  <= '0;
                        end else begin
                            // Next start bit follows the stop bit with no idle gap.
                            tx_state_q <= TX_START;
                            tx_q       <= 1'b0;
                            tx_byte_q  <= tx_byte_q + 1'b1;
                            tx_shift_q <= tx_vec_q[TVW-1 -: 8];
                            tx_vec_q   <= tx_vec_q << 8;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign tx       = tx_q;
    assign tx_ready = tx_ready_q;

    // ----------------------------------------------------------------- receive
    logic                          rx_s1_q, rx_s2_q, rx_s3_q;
    rx_state_t                     rx_state_q;
    logic [CW-1:0]                 rx_cnt_q;
    logic [2:0]                    rx_bit_q;
    logic [7:0]                    rx_shift_q;
    logic [7:0]                    rx_hi_q;
    logic                          rx_lo_q;
    logic [RWW-1:0]                rx_word_q;
    uart_pkg::num [n_rx_nums-1:0]  rx_nums_q;
    logic                          rx_avail_q;

    logic                          rx_fall;
    logic                          rx_done;
    logic                          rx_lo_eff;
    logic [RWW-1:0]                rx_word_eff;

    assign rx_fall = rx_s3_q && !rx_s2_q;
    assign rx_done = (rx_state_q == RX_STOP) && (rx_cnt_q == BIT_LAST) && rx_s2_q;

    // A new-vector request takes effect for a byte finishing in the same cycle.
    assign rx_lo_eff   = rx_lo_q && !new_vector_incoming;
    assign rx_word_eff = new_vector_incoming ? '0 : rx_word_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_hi_q    <= '0;
            rx_lo_q    <= 1'b0;
            rx_word_q  <= '0;
            rx_nums_q  <= '0;
            rx_avail_q <= 1'b0;
        end else begin
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_s3_q    <= rx_s2_q;
            rx_avail_q <= 1'b0;

            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase

            // A low stop bit leaves rx_done clear, so the byte is simply dropped.
            if (rx_done) begin
                if (!rx_lo_eff) begin
                    rx_hi_q   <= rx_shift_q;
                    rx_lo_q   <= 1'b1;
                    rx_word_q <= rx_word_eff;
                end else begin
                    rx_nums_q[rx_word_eff] <= {rx_hi_q, rx_shift_q};
                    rx_lo_q <= 1'b0;
                    if (rx_word_eff == RWW'(n_rx_nums - 1)) begin
                        rx_word_q  <= '0;
                        rx_avail_q <= 1'b1;
                    end else begin
                        rx_word_q <= rx_word_eff + 1'b1;
                    end
                end
            end else if (new_vector_incoming) begin
                rx_word_q <= '0;
                rx_lo_q   <= 1'b0;
            end
        end
    end

    assign rx_nums      = rx_nums_q;
    assign rx_available = rx_avail_q;

endmodule

// File: tb/tb_uart.sv
// Bench for uart: loopback vector with busy re-request, directed receive table,
// framing error, glitch, new-vector handling and mid-frame reset.
module tb_uart;
    localparam int N_TX = 5;
    localparam int N_RX = 5;
    localparam int CPB  = 100;
    localparam int TXC  = 2 * N_TX * 10 * CPB;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic send_data = 1'b0;
    logic rx_drv = 1'b1;
    logic loop_en = 1'b0;
    logic new_vector_incoming = 1'b0;
    uart_pkg::num [N_TX-1:0] tx_nums = '0;
    uart_pkg::num [N_RX-1:0] rx_nums;
    logic tx_ready, tx, rx, rx_available;

    int total = 0;
    int bad = 0;
    int avail_cnt = 0;
    logic [0:0] exp_q[$];

    typedef struct {
        int          kind;      // 0 word, 1 bad-stop byte, 2 lone byte, 3 glitch
        logic        nvi;
        logic [15:0] data;
        logic [2:0]  idx;
        logic [15:0] exp_val;
        int          exp_pulses;
    } rx_vec_t;
    rx_vec_t rv [10];

    uart #(.n_tx_nums(N_TX), .n_rx_nums(N_RX), .CLKS_PER_BIT(CPB)) dut (
        .clk                 (clk),
        .reset               (reset),
        .send_data           (send_data),
        .tx_nums             (tx_nums),
        .tx_ready            (tx_ready),
        .tx                  (tx),
        .rx                  (rx),
        .new_vector_incoming (new_vector_incoming),
        .rx_nums             (rx_nums),
        .rx_available        (rx_available)
    );

    assign rx = loop_en ? tx : rx_drv;

    always #5 clk = ~clk;

    always @(posedge clk) if (rx_available) avail_cnt <= avail_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx_drv = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[0];
            b = b >> 1;
            tick(CPB);
        end
        rx_drv = stop_bit;
        tick(CPB);
        rx_drv = 1'b1;
    endtask

    initial begin
        int snap;
        int ready_at;
        int idle_bad;
        logic [79:0] stream;
        logic [79:0] got_v;
        logic [79:0] exp_v;
        logic [7:0]  bv;

        rv[0] = '{0, 1'b0, 16'h1234, 3'd0, 16'h1234, 0};
        rv[1] = '{0, 1'b1, 16'h5678, 3'd0, 16'h5678, 0};
        rv[2] = '{0, 1'b0, 16'h1111, 3'd1, 16'h1111, 0};
        rv[3] = '{1, 1'b0, 16'h00EE, 3'd2, 16'hFD3C, 0};
        rv[4] = '{3, 1'b0, 16'h0000, 3'd2, 16'hFD3C, 0};
        rv[5] = '{0, 1'b0, 16'h2222, 3'd2, 16'h2222, 0};
        rv[6] = '{0, 1'b0, 16'h3333, 3'd3, 16'h3333, 0};
        rv[7] = '{0, 1'b0, 16'h4444, 3'd4, 16'h4444, 1};
        rv[8] = '{2, 1'b0, 16'h0099, 3'd0, 16'h5678, 0};
        rv[9] = '{0, 1'b1, 16'h6666, 3'd0, 16'h6666, 0};

        // Reset state
        #50;
        check("reset tx", 32'(tx), 32'd1);
        check("reset tx_ready", 32'(tx_ready), 32'd1);
        check("reset rx_available", 32'(rx_available), 32'd0);
        check("reset rx_nums", 32'(|rx_nums), 32'd0);
        #50 reset = 1'b0;
        tick(3);

        // Loopback: one vector, plus an ignored request while busy
        stream = 80'hDABE_00C1_FD3C_FEDA_F6A5;
        for (int k = 0; k < 10; k++) begin
            bv = stream[79:72];
            stream = stream << 8;
            exp_q.push_back(1'b0);
            for (int b = 0; b < 8; b++) begin
                exp_q.push_back(bv[0]);
                bv = bv >> 1;
            end
            exp_q.push_back(1'b1);
        end
        loop_en = 1'b1;
        tx_nums = {16'hF6A5, 16'hFEDA, 16'hFD3C, 16'h00C1, 16'hDABE};
        send_data = 1'b1;
        tick(1);
        send_data = 1'b0;
        check("tx_ready drop", 32'(tx_ready), 32'd0);
        snap = avail_cnt;
        ready_at = -1;
        for (int c = 0; c <= TXC + 4 * CPB; c++) begin
            if ((c % CPB) == CPB / 2 && exp_q.size() > 0)
                check($sformatf("tx bit %0d", c / CPB), 32'(tx), 32'(exp_q.pop_front()));
            if (ready_at < 0 && tx_ready) ready_at = c;
            if (c == 3000) begin
                send_data = 1'b1;
                tx_nums = {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
            end
            if (c == 3001) send_data = 1'b0;
            tick(1);
        end
        check("tx_ready low cycles", ready_at, TXC);
        check("tx bits left", exp_q.size(), 0);
        check("loopback pulses", avail_cnt - snap, 1);
        check("tx idle after", 32'(tx), 32'd1);
        check("tx_ready after", 32'(tx_ready), 32'd1);
        got_v = rx_nums;
        exp_v = 80'hF6A5_FEDA_FD3C_00C1_DABE;
        for (int w = 0; w < N_RX; w++) begin
            check($sformatf("loopback word %0d", w), {16'h0, got_v[15:0]}, {16'h0, exp_v[15:0]});
            got_v = got_v >> 16;
            exp_v = exp_v >> 16;
        end

        // Directed receive table
        loop_en = 1'b0;
        rx_drv = 1'b1;
        tick(CPB);
        for (int i = 0; i < 10; i++) begin
            snap = avail_cnt;
            if (rv[i].nvi) begin
                new_vector_incoming = 1'b1;
                tick(1);
                new_vector_incoming = 1'b0;
            end
            case (rv[i].kind)
                0: begin
                    send_byte(rv[i].data[15:8], 1'b1);
                    send_byte(rv[i].data[7:0], 1'b1);
                end
                1: send_byte(rv[i].data[7:0], 1'b0);
                2: send_byte(rv[i].data[7:0], 1'b1);
                default: begin
                    rx_drv = 1'b0;
                    tick(10);
                    rx_drv = 1'b1;
                end
            endcase
            tick(2 * CPB);
            check($sformatf("rx vec %0d word", i), 32'($unsigned(rx_nums[rv[i].idx])), {16'h0, rv[i].exp_val});
            check($sformatf("rx vec %0d pulses", i), avail_cnt - snap, rv[i].exp_pulses);
        end

        // Reset in the middle of a loopback frame
        loop_en = 1'b1;
        tx_nums = {16'hF6A5, 16'hFEDA, 16'hFD3C, 16'h00C1, 16'hDABE};
        send_data = 1'b1;
        tick(1);
        send_data = 1'b0;
        tick(1050);
        check("pre-reset tx start bit", 32'(tx), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("mid reset tx", 32'(tx), 32'd1);
        check("mid reset tx_ready", 32'(tx_ready), 32'd1);
        check("mid reset rx_available", 32'(rx_available), 32'd0);
        check("mid reset rx_nums", 32'(|rx_nums), 32'd0);
        tick(2);
        reset = 1'b0;
        idle_bad = 0;
        for (int c = 0; c < 3 * CPB; c++) begin
            if (tx !== 1'b1 || tx_ready !== 1'b1) idle_bad++;
            tick(1);
        end
        check("idle after reset", idle_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
